// File: rtl/led_share_sched.sv
// Round-robin owner of a single board LED: each grant blinks BLINKS times, then a dark gap and a done pulse.
// Latency: grant/led one cycle after a request. Phases last hp*TICK_DIV cycles. Dropping req aborts at the next edge.
module led_share_sched #(
   parameter int N_REQ    = 4,
   parameter int TICK_DIV = 12_500_000,
   parameter int BLINKS   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [4*N_REQ-1:0]   half_period,
   output logic                 led,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic [N_REQ-1:0]     done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINKS) + 1;
   localparam int IW = $clog2(N_REQ);
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINKS - 1);
   localparam logic [IW-1:0] RR_INIT    = IW'(N_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   state_t           state_q, state_d;
   logic             led_q, led_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [3:0]       half_cnt_q, half_cnt_d;
   logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
   logic [IW-1:0]    rr_last_q, rr_last_d;
   logic [IW-1:0]    win_q, win_d;
   logic [3:0]       hp_q, hp_d;

   logic             found;
   logic [IW-1:0]    win;
   logic [IW-1:0]    idx;
   logic [3:0]       hp_sel;
   logic             tick;

   // Search starts just past the last owner so a persistent requester goes to the back.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      idx    = '0;
      hp_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(rr_last_q) + 1 + k) % N_REQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      hp_sel = half_period[int'(win)*4 +: 4];
      if (hp_sel == 4'd0) begin
         hp_sel = 4'd1;
      end
   end

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      state_d     = state_q;
      led_d       = led_q;
      grant_d     = grant_q;
      done_d      = '0;
      presc_d     = presc_q;
      half_cnt_d  = half_cnt_q;
      blink_cnt_d = blink_cnt_q;
      rr_last_d   = rr_last_q;
      win_d       = win_q;
      hp_d        = hp_q;

      if (state_q == S_IDLE) begin
         presc_d = '0;
         led_d   = 1'b0;
         grant_d = '0;
         if (found) begin
            grant_d      = '0;
            grant_d[win] = 1'b1;
            rr_last_d    = win;
            win_d        = win;
            hp_d         = hp_sel;
            half_cnt_d   = hp_sel - 4'd1;
            blink_cnt_d  = '0;
            led_d        = 1'b1;
            state_d      = S_ON;
         end
      end else if (!req[win_q]) begin
         // Abort wins over any tick landing on the same edge.
         state_d = S_IDLE;
         led_d   = 1'b0;
         grant_d = '0;
         presc_d = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (half_cnt_q != 4'd0) begin
               half_cnt_d = half_cnt_q - 4'd1;
            end else begin
               half_cnt_d = hp_q - 4'd1;
               case (state_q)
                  S_ON: begin
                     state_d = S_OFF;
                     led_d   = 1'b0;
                  end
                  S_OFF: begin
                     if (blink_cnt_q < BLINK_LAST) begin
                        state_d     = S_ON;
                        led_d       = 1'b1;
                        blink_cnt_d = blink_cnt_q + BW'(1);
                     end else begin
                        state_d = S_GAP;
                     end
                  end
                  default: begin
                     state_d = S_IDLE;
                     done_d  = grant_q;
                     grant_d = '0;
                     led_d   = 1'b0;
                     presc_d = '0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         led_q       <= 1'b0;
         grant_q     <= '0;
         done_q      <= '0;
         presc_q     <= '0;
         half_cnt_q  <= '0;
         blink_cnt_q <= '0;
         rr_last_q   <= RR_INIT;
         win_q       <= '0;
         hp_q        <= 4'd1;
      end else begin
         state_q     <= state_d;
         led_q       <= led_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         presc_q     <= presc_d;
         half_cnt_q  <= half_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         rr_last_q   <= rr_last_d;
         win_q       <= win_d;
         hp_q        <= hp_d;
      end
   end

   assign led   = led_q;
   assign grant = grant_q;
   assign done  = done_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_share_sched.sv
// Scoreboard bench: stimulus pushes the expected {led,grant,busy,done} for each cycle, a negedge monitor pops and compares.
module tb_led_share_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] half_period;
   logic        led;
   logic [3:0]  grant;
   logic        busy;
   logic [3:0]  done;

   logic [9:0]  exp_q[$];
   int          n_chk;
   int          n_pass;
   int          mon_cyc;

   led_share_sched #(
      .N_REQ    (4),
      .TICK_DIV (4),
      .BLINKS   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .half_period (half_period),
      .led         (led),
      .grant       (grant),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s t=%0t got led=%b grant=%b busy=%b done=%b want led=%b grant=%b busy=%b done=%b",
                  name, $time, act[9], act[8:5], act[4], act[3:0], exp[9], exp[8:5], exp[4], exp[3:0]);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [9:0] e;
         e = exp_q.pop_front();
         mon_cyc++;
         chk($sformatf("trace[%0d]", mon_cyc), {led, grant, busy, done}, e);
      end
   end

   task automatic cyc(input logic l, input logic [3:0] g, input logic b, input logic [3:0] d);
      @(posedge clk);
      #1;
      exp_q.push_back({l, g, b, d});
   endtask

   task automatic phase(input logic l, input logic [3:0] g, input int n);
      for (int i = 0; i < n; i++) cyc(l, g, 1'b1, 4'b0000);
   endtask

   task automatic grant_seq(input logic [3:0] g, input int n);
      phase(1'b1, g, n);
      phase(1'b0, g, n);
      phase(1'b1, g, n);
      phase(1'b0, g, n);
      phase(1'b0, g, n);
      cyc(1'b0, 4'b0000, 1'b0, g);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      mon_cyc     = 0;
      rst         = 1'b0;
      req         = 4'b0000;
      half_period = 16'h1111;
      #2;
      chk("reset_state", {led, grant, busy, done}, 10'b0);
      #10;
      rst = 1'b1;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // single request, hp=1: 4-cycle phases
      req = 4'b0001;
      grant_seq(4'b0001, 4);
      req = 4'b0000;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // async reset mid-ON, checked without a clock edge
      req = 4'b0010;
      cyc(1'b1, 4'b0010, 1'b1, 4'b0000);
      cyc(1'b1, 4'b0010, 1'b1, 4'b0000);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst", {led, grant, busy, done}, 10'b0);
      req = 4'b0000;
      #1;
      rst = 1'b1;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // round robin between 0 and 2
      req = 4'b0101;
      grant_seq(4'b0001, 4);
      grant_seq(4'b0100, 4);
      grant_seq(4'b0001, 4);
      grant_seq(4'b0100, 4);
      req = 4'b0000;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // zero half-period behaves as 1
      half_period[15:12] = 4'd0;
      req = 4'b1000;
      grant_seq(4'b1000, 4);
      req = 4'b0000;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // hp=3, changing half_period mid-grant has no effect
      half_period[7:4] = 4'd3;
      req = 4'b0010;
      phase(1'b1, 4'b0010, 12);
      half_period[7:4] = 4'd1;
      phase(1'b0, 4'b0010, 12);
      phase(1'b1, 4'b0010, 12);
      phase(1'b0, 4'b0010, 12);
      phase(1'b0, 4'b0010, 12);
      cyc(1'b0, 4'b0000, 1'b0, 4'b0010);
      req = 4'b0000;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      // abort in OFF cycle 2 with req[2] pending
      req = 4'b0010;
      cyc(1'b1, 4'b0010, 1'b1, 4'b0000);
      req = 4'b0110;
      phase(1'b1, 4'b0010, 3);
      phase(1'b0, 4'b0010, 2);
      req = 4'b0100;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);
      cyc(1'b1, 4'b0100, 1'b1, 4'b0000);
      req = 4'b0000;
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);
      cyc(1'b0, 4'b0000, 1'b0, 4'b0000);

      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL queue_drained got %0d pending want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/led_share_sched.md
Name: led_share_sched

Overview:
- Round-robin scheduler that shares a single board LED between N_REQ requesters.
- Each requester holds a level request and supplies a blink half-period. The granted requester gets BLINKS on/off cycles, then a separating off gap, then a one-cycle done pulse.
- Sits between status sources (error flags, heartbeat, link-up) and the LED pin. It replaces ad-hoc per-source blink counters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TICK_DIV, 12_500_000, clk cycles per timing tick (0.25 s at 50 MHz); must be >= 2.
- BLINKS, 3, on/off cycles per grant (>= 1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; hold high until done or to abort.
- half_period  in  4*N_REQ  per-requester half-period in ticks, slice i = bits [4i+3:4i]; value 0 treated as 1.
- led  out  1  LED drive, registered.
- grant  out  N_REQ  one-hot current owner, registered; all-zero when idle.
- busy  out  1  high whenever state != IDLE.
- done  out  N_REQ  one-cycle one-hot pulse on normal completion.

Behaviour:
- Reset (rst low, async): state=IDLE, led=0, grant=0, busy=0, done=0, prescaler=0, half_cnt=0, blink_cnt=0, rr_last=N_REQ-1. Reset low mid-operation clears everything immediately, without waiting for a clock edge.
- Prescaler:
  - Held at 0 in IDLE. Otherwise counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler==TICK_DIV-1), one-cycle pulse.
  - First tick occurs TICK_DIV cycles after leaving IDLE.
- Arbitration (IDLE only):
  - Search req starting at index (rr_last+1) mod N_REQ, wrapping. The first set bit wins.
  - On the winning edge: grant=onehot(win), rr_last=win, hp=max(half_period[win],1) latched, half_cnt=hp-1, blink_cnt=0, led=1, state=ON.
  - Latency: req seen high at edge t gives grant/led high after edge t (one registered cycle).
  - half_period is sampled only at grant; later changes are ignored.
- FSM, transitions evaluated on tick only, otherwise hold. On each tick: if half_cnt!=0, decrement; else reload half_cnt=hp-1 and transition:
  - ON -> OFF, led=0.
  - OFF -> ON (led=1, blink_cnt+1) if blink_cnt<BLINKS-1; else OFF -> GAP.
  - GAP -> IDLE: done[win]=1 for exactly one cycle, grant=0, led=0.
- Phase durations: each of ON, OFF and GAP lasts exactly hp*TICK_DIV cycles. Total grant = (2*BLINKS+1)*hp*TICK_DIV cycles.
- Abort:
  - If req[win] is low at any edge in ON, OFF or GAP, go to IDLE at that edge: led=0, grant=0, no done pulse.
  - Abort has priority over a simultaneous tick.
- Back-to-back grants:
  - A new grant can occur on the edge following return to IDLE; there is at least one cycle with grant=0 between owners.
  - A requester still holding req after done re-enters arbitration behind the others (rr_last = itself).
- Widths:
  - half_cnt is 4 bits.
  - blink_cnt is clog2(BLINKS)+1 bits.
  - prescaler is clog2(TICK_DIV) bits.
- Invariants:
  - grant is always one-hot or zero.
  - done is never asserted together with a nonzero grant for a different owner.
  - led=1 only in ON.

Test Plan (TICK_DIV=4, BLINKS=2, N_REQ=4 unless noted):
- Reset: drive rst=0 mid-ON with no clock edge -> led=0, grant=0, busy=0, done=0 immediately. Release, req=0 -> outputs stay 0.
- Single request: req=0001, half_period[0]=1.
  - Grant=0001 one cycle after req.
  - led pattern over 20 cycles: 1 (4 cycles), 0 (4), 1 (4), 0 (4), 0 (4, GAP).
  - done=0001 for 1 cycle, then grant=0, busy=0.
- Round-robin: req=0101 held from reset -> grant order 0001, 0100, 0001, 0100, with one idle cycle between owners.
- Zero half-period: half_period[3]=0, req=1000 -> identical timing to hp=1 (ON = 4 cycles).
- hp=3 on req1 -> each phase is 12 cycles. Change half_period[1] to 1 mid-grant -> timing unchanged.
- Abort: drop req[1] in cycle 2 of OFF -> next edge: state IDLE, grant=0, led=0, done stays 0. A pending req[2] is granted on the following edge.
